// File: rtl/maze_grid_sram.sv
// Single-port grid memory for the maze router with per-bit write mask,
// 1- or 2-cycle registered reads and a clear engine that fills the whole grid.
module maze_grid_sram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int RAM_DEPTH  = 64,
    parameter int READ_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] wmask,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    input  logic                  clr_start,
    input  logic [DATA_WIDTH-1:0] clr_value,
    output logic                  busy,
    output logic                  clr_done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic [1:0]            state_reg, state_next;
    logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;
    logic [DATA_WIDTH-1:0] fill_reg, fill_next;

    logic                  in_range;
    logic                  clr_accept;
    logic                  user_ok;
    logic                  user_wr;
    logic                  user_rd;

    logic                  rd1_valid_reg;
    logic [DATA_WIDTH-1:0] rd1_data_reg;

    assign in_range   = ({1'b0, address} < (ADDR_WIDTH + 1)'(RAM_DEPTH));
    // A clear request in the same cycle as a user access takes priority.
    assign clr_accept = (state_reg == ST_IDLE) && clr_start;
    assign user_ok    = (state_reg != ST_CLEAR) && !clr_accept;
    assign user_wr    = user_ok && cs && we && in_range;
    assign user_rd    = user_ok && cs && !we;

    assign busy     = (state_reg == ST_CLEAR);
    assign clr_done = (state_reg == ST_DONE);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        fill_next  = fill_reg;
        case (state_reg)
            ST_IDLE: begin
                if (clr_start) begin
                    state_next = ST_CLEAR;
                    cnt_next   = '0;
                    fill_next  = clr_value;
                end
            end
            ST_CLEAR: begin
                if (cnt_reg == LAST_ADDR) begin
                    state_next = ST_DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            fill_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            fill_reg  <= fill_next;
        end
    end

    // Storage has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (state_reg == ST_CLEAR) begin
            mem[cnt_reg] <= fill_reg;
        end else if (user_wr) begin
            mem[address] <= (mem[address] & ~wmask) | (data_in & wmask);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd1_valid_reg <= 1'b0;
            rd1_data_reg  <= '0;
        end else begin
            rd1_valid_reg <= user_rd;
            if (user_rd) begin
                rd1_data_reg <= in_range ? mem[address] : '0;
            end
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic                  rd2_valid_reg;
            logic [DATA_WIDTH-1:0] rd2_data_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd2_valid_reg <= 1'b0;
                    rd2_data_reg  <= '0;
                end else begin
                    rd2_valid_reg <= rd1_valid_reg;
                    if (rd1_valid_reg) begin
                        rd2_data_reg <= rd1_data_reg;
                    end
                end
            end

            assign data_out = rd2_data_reg;
            assign rd_valid = rd2_valid_reg;
        end else begin : g_lat1
            assign data_out = rd1_data_reg;
            assign rd_valid = rd1_valid_reg;
        end
    endgenerate

endmodule

// File: tb/tb_maze_grid_sram.sv
// Scoreboard bench: two instances (64 cells / latency 1 and 48 cells / latency 2)
// share one stimulus stream; a cell-level reference model predicts every response.
module tb_maze_grid_sram;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cs = 1'b0;
    logic       we = 1'b0;
    logic [5:0] address = '0;
    logic [7:0] data_in = '0;
    logic [7:0] wmask = '0;
    logic       clr_start = 1'b0;
    logic [7:0] clr_value = '0;

    logic [7:0] dout_a, dout_b;
    logic       rdv_a, rdv_b, busy_a, busy_b, done_a, done_b;

    always #5 clk = ~clk;

    maze_grid_sram #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .RAM_DEPTH(64), .READ_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .cs(cs), .we(we), .address(address), .data_in(data_in),
        .wmask(wmask), .data_out(dout_a), .rd_valid(rdv_a), .clr_start(clr_start),
        .clr_value(clr_value), .busy(busy_a), .clr_done(done_a)
    );

    maze_grid_sram #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .RAM_DEPTH(48), .READ_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .cs(cs), .we(we), .address(address), .data_in(data_in),
        .wmask(wmask), .data_out(dout_b), .rd_valid(rdv_b), .clr_start(clr_start),
        .clr_value(clr_value), .busy(busy_b), .clr_done(done_b)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: cell contents, remaining clear cycles and done flag per instance.
    typedef struct {
        logic [7:0] data;
        int         due;
    } rd_t;

    int         depth [2] = '{64, 48};
    int         lat [2]   = '{1, 2};
    logic [7:0] mdl [2][64];
    int         clr_left [2];
    bit         done_now [2];
    logic [7:0] fill [2];
    logic [7:0] last_data [2];
    rd_t        q0 [$];
    rd_t        q1 [$];

    function automatic void check(string name, int k, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h (cycle %0d)", name, k, act, exp, cyc);
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            clr_left[k]  = 0;
            done_now[k]  = 1'b0;
            last_data[k] = 8'h00;
        end
        q0.delete();
        q1.delete();
    endfunction

    function automatic void model_step(int k);
        rd_t e;
        if (clr_left[k] > 0) begin
            mdl[k][depth[k] - clr_left[k]] = fill[k];
            clr_left[k]--;
            if (clr_left[k] == 0) done_now[k] = 1'b1;
        end else begin
            if (!done_now[k] && clr_start) begin
                clr_left[k] = depth[k];
                fill[k]     = clr_value;
            end else if (cs) begin
                if (we) begin
                    if (int'(address) < depth[k])
                        mdl[k][address] = (mdl[k][address] & ~wmask) | (data_in & wmask);
                end else begin
                    e.data = (int'(address) < depth[k]) ? mdl[k][address] : 8'h00;
                    e.due  = cyc + lat[k];
                    if (k == 0) q0.push_back(e);
                    else q1.push_back(e);
                end
            end
            done_now[k] = 1'b0;
        end
    endfunction

    task automatic cycle(bit c, bit w, int a, logic [7:0] d, logic [7:0] m, bit cst, logic [7:0] cv);
        @(negedge clk);
        cs        = c;
        we        = w;
        address   = 6'(a);
        data_in   = d;
        wmask     = m;
        clr_start = cst;
        clr_value = cv;
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check("busy", 0, busy_a, clr_left[0] > 0);
        check("busy", 1, busy_b, clr_left[1] > 0);
        check("clr_done", 0, done_a, done_now[0]);
        check("clr_done", 1, done_b, done_now[1]);
    endtask

    task automatic idle();                        cycle(0, 0, 0, 8'h00, 8'h00, 0, 8'h00); endtask
    task automatic wr(int a, logic [7:0] d);      cycle(1, 1, a, d, 8'hFF, 0, 8'h00); endtask
    task automatic wrm(int a, logic [7:0] d, logic [7:0] m); cycle(1, 1, a, d, m, 0, 8'h00); endtask
    task automatic rd(int a);                     cycle(1, 0, a, 8'h00, 8'h00, 0, 8'h00); endtask
    task automatic clr(logic [7:0] v);            cycle(0, 0, 0, 8'h00, 8'h00, 1, v); endtask

    task automatic wait_clear();
        int guard = 0;
        while ((clr_left[0] > 0 || clr_left[1] > 0) && guard < 200) begin
            idle();
            guard++;
        end
    endtask

    // Asynchronous reset raised between clock edges and checked before the next edge.
    task automatic do_reset();
        idle();
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst data_out", 0, dout_a, 8'h00);
        check("rst data_out", 1, dout_b, 8'h00);
        check("rst rd_valid", 0, rdv_a, 1'b0);
        check("rst rd_valid", 1, rdv_b, 1'b0);
        check("rst busy", 0, busy_a, 1'b0);
        check("rst busy", 1, busy_b, 1'b0);
        check("rst clr_done", 0, done_a, 1'b0);
        check("rst clr_done", 1, done_b, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic mon(int k, logic v, logic [7:0] d);
        bit  exp_v;
        rd_t e;
        exp_v = 1'b0;
        e.data = 8'h00;
        e.due  = 0;
        if (k == 0) begin
            if (q0.size() > 0 && q0[0].due == cyc) begin exp_v = 1'b1; e = q0.pop_front(); end
        end else begin
            if (q1.size() > 0 && q1[0].due == cyc) begin exp_v = 1'b1; e = q1.pop_front(); end
        end
        check("rd_valid", k, v, exp_v);
        if (exp_v) begin
            last_data[k] = e.data;
            $display("dut%0d read completes cycle %0d: data_out=0x%02h expected 0x%02h", k, cyc, d, e.data);
        end
        check("data_out", k, d, last_data[k]);
    endtask

    always @(negedge clk) begin
        mon(0, rdv_a, dout_a);
        mon(1, rdv_b, dout_b);
    end

    initial begin
        model_reset();
        #1;
        rst = 1'b1;
        #2;
        check("por busy", 0, busy_a, 1'b0);
        check("por busy", 1, busy_b, 1'b0);
        check("por rd_valid", 0, rdv_a, 1'b0);
        check("por data_out", 1, dout_b, 8'h00);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Known contents first, then reset mid-activity.
        clr(8'h00);
        wait_clear();
        wr(3, 8'h5A);
        rd(3);
        do_reset();
        rd(3);
        idle(); idle(); idle();

        // Masked writes.
        wr(10, 8'hFF);
        wrm(10, 8'h00, 8'h0F);
        rd(10);
        wrm(10, 8'h12, 8'h00);
        rd(10);
        idle(); idle();

        // Back-to-back pipelined reads and read-before-write on the same cell.
        for (int i = 0; i < 4; i++) wr(i, 8'(8'h10 + i));
        for (int i = 0; i < 4; i++) rd(i);
        rd(7);
        wr(7, 8'hAB);
        rd(7);
        idle(); idle(); idle();

        // Full clear with a dropped write and an ignored second request.
        clr(8'hEE);
        idle();
        wr(5, 8'h11);
        clr(8'h55);
        wait_clear();
        wr(9, 8'h9C);
        rd(0); rd(31); rd(63); rd(5); rd(47); rd(9);
        idle(); idle(); idle();

        // Reset in the middle of a clear.
        for (int i = 0; i < 64; i++) wr(i, 8'h33);
        clr(8'h00);
        for (int i = 0; i < 19; i++) idle();
        do_reset();
        for (int i = 0; i < 64; i++) rd(i);
        idle(); idle(); idle();

        // Out-of-range and last-cell accesses, then a clear of both depths.
        wr(50, 8'h77);
        rd(50);
        wr(47, 8'h47);
        rd(47);
        clr(8'h99);
        wait_clear();
        idle();
        rd(47); rd(50); rd(63);
        idle(); idle(); idle();

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                cycle(0, 0, 0, 8'h00, 8'h00, 1, 8'($urandom));
            end else begin
                cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 63)), 8'($urandom),
                      ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom),
                      (r < 4), 8'($urandom));
            end
        end
        wait_clear();
        for (int i = 0; i < 4; i++) idle();
        check("drain", 0, q0.size(), 0);
        check("drain", 1, q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
